// File: rtl/rand_pkg.sv
// rand_pkg: shared constants and types for the pseudo-random source.
//   LFSR_W      LFSR width (10)
//   TAP_HI/LO   feedback tap bit indices (x^10 + x^7 + 1 -> bits 9 and 6)
//   LFSR_PERIOD maximal-length period (2^10 - 1)
//   rand_t      LFSR state / comparator B operand type
//   lfsr_next   one Fibonacci shift-left step
package rand_pkg;
  localparam int unsigned LFSR_W      = 10;
  localparam int unsigned TAP_HI      = 9;
  localparam int unsigned TAP_LO      = 6;
  localparam int unsigned LFSR_PERIOD = 1023;

  typedef logic [LFSR_W-1:0] rand_t;

  function automatic rand_t lfsr_next(input rand_t q);
    return {q[LFSR_W-2:0], q[TAP_HI] ^ q[TAP_LO]};
  endfunction
endpackage

// File: rtl/rate_divider.sv
// rate_divider: counts 0..DIV-1 while en=1 and strobes step on the last count.
//   clk   in  system clock
//   rst   in  synchronous active-high reset (count -> 0)
//   en    in  advance the count; en=0 holds it
//   clr   in  synchronous clear of the count (higher priority than en)
//   step  out strobe, high while en=1 and the count is at DIV-1
module rate_divider #(
  parameter int unsigned DIV = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic step
);
  localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    step  = en && (cnt_q == LAST);
    cnt_d = cnt_q;
    if (clr)       cnt_d = '0;
    else if (step) cnt_d = '0;
    else if (en)   cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end
endmodule

// File: rtl/lfsr_rand_source.sv
// lfsr_rand_source: 10-bit maximal-length LFSR stepped at a programmable rate,
// with seed load and all-zero lockup recovery. Q feeds the comparator B input.
//   Clock   in  system clock
//   Reset   in  synchronous active-high reset
//   step_en in  enables the rate divider / stepping
//   seed_ld in  load seed this cycle (zero seed replaced by SEED_DEFAULT)
//   seed    in  seed value
//   Q       out registered LFSR state
//   q_valid out 1-cycle pulse when Q changed by a step
//   wrap    out 1-cycle pulse when a step returns Q to the last loaded seed
// Optional feature macro: LFSR_PERIOD_CHECK_EN (step counter, wrap, period assertion).
// Without it wrap is tied 0.
module lfsr_rand_source
  import rand_pkg::*;
#(
  parameter int unsigned       WIDTH        = 10,
  parameter int unsigned       DIV          = 1,
  parameter logic [WIDTH-1:0]  SEED_DEFAULT = 10'h001
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             step_en,
  input  logic             seed_ld,
  input  logic [WIDTH-1:0] seed,
  output logic [WIDTH-1:0] Q,
  output logic             q_valid,
  output logic             wrap
);
  rand_t q_q, q_d;
  logic  q_valid_q, q_valid_d;
  logic  step;

  rate_divider #(.DIV(DIV)) u_div (
    .clk  (Clock),
    .rst  (Reset),
    .en   (step_en),
    .clr  (seed_ld),
    .step (step)
  );

  // Priority: seed load, then lockup recovery, then step.
  always_comb begin
    q_d       = q_q;
    q_valid_d = 1'b0;
    if (seed_ld) begin
      q_d = (seed == '0) ? SEED_DEFAULT : seed;
    end else if (q_q == '0) begin
      q_d = SEED_DEFAULT;
    end else if (step) begin
      q_d       = lfsr_next(q_q);
      q_valid_d = 1'b1;
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      q_q       <= SEED_DEFAULT;
      q_valid_q <= 1'b0;
    end else begin
      q_q       <= q_d;
      q_valid_q <= q_valid_d;
    end
  end

  assign Q       = q_q;
  assign q_valid = q_valid_q;

`ifdef LFSR_PERIOD_CHECK_EN
  rand_t            ref_seed_q, ref_seed_d;
  logic [WIDTH-1:0] step_cnt_q, step_cnt_d;
  logic             wrap_q, wrap_d;

  always_comb begin
    ref_seed_d = ref_seed_q;
    step_cnt_d = step_cnt_q;
    wrap_d     = 1'b0;
    if (seed_ld) begin
      ref_seed_d = q_d;
      step_cnt_d = '0;
    end else if (q_valid_d) begin
      wrap_d     = (q_d == ref_seed_q);
      step_cnt_d = wrap_d ? '0 : step_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      ref_seed_q <= SEED_DEFAULT;
      step_cnt_q <= '0;
      wrap_q     <= 1'b0;
    end else begin
      ref_seed_q <= ref_seed_d;
      step_cnt_q <= step_cnt_d;
      wrap_q     <= wrap_d;
      // The wrapping step is the (count+1)-th step since the seed was loaded.
      if (wrap_d)
        assert (step_cnt_q == WIDTH'(LFSR_PERIOD - 1))
          else $error("lfsr period wrong: %0d steps", step_cnt_q + 1'b1);
    end
  end

  assign wrap = wrap_q;
`else
  assign wrap = 1'b0;
`endif
endmodule

// File: tb/tb_lfsr_rand_source.sv
module tb_lfsr_rand_source;
  logic       clk;
  logic       Reset;
  logic       en1, ld1, en4, ld4;
  logic [9:0] seed;
  logic [9:0] q1, q4;
  logic       qv1, qv4, wrap1, wrap4;

  int n_assert = 0;
  int n_fail   = 0;

  lfsr_rand_source #(.WIDTH(10), .DIV(1), .SEED_DEFAULT(10'h001)) dut1 (
    .Clock(clk), .Reset(Reset), .step_en(en1), .seed_ld(ld1), .seed(seed),
    .Q(q1), .q_valid(qv1), .wrap(wrap1)
  );

  lfsr_rand_source #(.WIDTH(10), .DIV(4), .SEED_DEFAULT(10'h001)) dut4 (
    .Clock(clk), .Reset(Reset), .step_en(en4), .seed_ld(ld4), .seed(seed),
    .Q(q4), .q_valid(qv4), .wrap(wrap4)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
      else begin
        n_fail++;
        $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
  endtask

  logic [9:0] seq2 [10];
  logic [9:0] e;

  initial begin
    seq2 = '{10'h002, 10'h004, 10'h008, 10'h010, 10'h020,
             10'h040, 10'h081, 10'h102, 10'h204, 10'h009};
    Reset = 1'b1; en1 = 1'b0; ld1 = 1'b0; en4 = 1'b0; ld4 = 1'b0; seed = '0;

    // 1. reset and hold
    tick(); tick();
    check("reset_q1", 32'(q1), 32'h001);
    check("reset_qv1", 32'(qv1), 0);
    check("reset_q4", 32'(q4), 32'h001);
    check("reset_wrap", 32'(wrap1), 0);
    Reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("hold_q1", 32'(q1), 32'h001);
      check("hold_q4", 32'(q4), 32'h001);
      check("hold_qv1", 32'(qv1), 0);
    end

    // 2. DIV=1 sequence from seed 1
    en1 = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("seq_q", 32'(q1), 32'(seq2[i]));
      check("seq_qv", 32'(qv1), 1);
    end
    en1 = 1'b0;
    tick();
    check("seq_stop_qv", 32'(qv1), 0);
    check("seq_stop_q", 32'(q1), 32'h009);

    // 3. DIV=4 stepping, pause at count 2
    en4 = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      e = (i < 3) ? 10'h001 : (i < 7) ? 10'h002 : 10'h004;
      check("div4_q", 32'(q4), 32'(e));
      check("div4_qv", 32'(qv4), (i == 3 || i == 7) ? 1 : 0);
    end
    tick(); tick();
    check("div4_cnt2_q", 32'(q4), 32'h004);
    check("div4_cnt2_qv", 32'(qv4), 0);
    en4 = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("div4_pause_q", 32'(q4), 32'h004);
      check("div4_pause_qv", 32'(qv4), 0);
    end
    en4 = 1'b1;
    tick();
    check("div4_resume1_qv", 32'(qv4), 0);
    check("div4_resume1_q", 32'(q4), 32'h004);
    tick();
    check("div4_resume2_qv", 32'(qv4), 1);
    check("div4_resume2_q", 32'(q4), 32'h008);
    en4 = 1'b0;

    // 4. seed load: zero seed substituted, load beats a pending step
    en1 = 1'b1; ld1 = 1'b1; seed = 10'h000;
    tick();
    check("seed0_q", 32'(q1), 32'h001);
    check("seed0_qv", 32'(qv1), 0);
    seed = 10'h2C8;
    tick();
    check("seed2c8_q", 32'(q1), 32'h2C8);
    check("seed2c8_qv", 32'(qv1), 0);
    ld1 = 1'b0;
    tick();
    check("seed2c8_step_q", 32'(q1), 32'h190);
    check("seed2c8_step_qv", 32'(qv1), 1);
    en1 = 1'b0;
    tick();
    check("seed_idle_qv", 32'(qv1), 0);

    // 5a. lockup recovery
    force dut1.q_q = 10'h000;
    #1;
    release dut1.q_q;
    tick();
    check("lockup_q", 32'(q1), 32'h001);
    check("lockup_qv", 32'(qv1), 0);

    // 5b. reset mid-division discards partial count
    en4 = 1'b1;
    tick(); tick();
    check("middiv_q", 32'(q4), 32'h008);
    Reset = 1'b1;
    tick();
    check("middiv_rst_q", 32'(q4), 32'h001);
    check("middiv_rst_qv", 32'(qv4), 0);
    check("middiv_rst_cnt", 32'(dut4.u_div.cnt_q), 0);
    Reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("postrst_q", 32'(q4), (i == 3) ? 32'h002 : 32'h001);
      check("postrst_qv", 32'(qv4), (i == 3) ? 1 : 0);
    end
    en4 = 1'b0;

`ifdef LFSR_PERIOD_CHECK_EN
    // 6. full period from seed 12C
    begin
      bit seen [1024];
      int distinct;
      bit dup;
      distinct = 0;
      dup = 1'b0;
      ld1 = 1'b1; seed = 10'h12C;
      tick();
      ld1 = 1'b0; en1 = 1'b1;
      for (int k = 1; k <= 2046; k++) begin
        tick();
        check("period_wrap", 32'(wrap1), (k == 1023 || k == 2046) ? 1 : 0);
        if (k <= 1023) begin
          if (seen[q1]) dup = 1'b1;
          else distinct++;
          seen[q1] = 1'b1;
        end
      end
      en1 = 1'b0;
      check("period_distinct", 32'(distinct), 1023);
      check("period_dup", 32'(dup), 0);
      check("period_no_zero", 32'(seen[0]), 0);
    end
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
